// File: rtl/regfile_wb.sv
// MEM/WB pipeline register and 32x32 register file for the MIPS pipeline.
// Two combinational read ports bypass the pending WB-stage write.
module regfile_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [4:0]            WriteRegister_M,
    input  logic                  RegWrite_M,
    input  logic                  MemToReg_M,
    input  logic [DATA_WIDTH-1:0] ALUResult_M,
    input  logic [DATA_WIDTH-1:0] MemReadData_M,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [4:0]            WBRegister,
    output logic                  WBRegWrite,
    output logic [DATA_WIDTH-1:0] WBData
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] sel_data;

    assign sel_data = MemToReg_M ? MemReadData_M : ALUResult_M;

    // Flush wins over Stall so a bubble is always inserted
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            WBRegister <= '0;
            WBRegWrite <= 1'b0;
            WBData     <= '0;
        end else if (Flush) begin
            WBRegister <= '0;
            WBRegWrite <= 1'b0;
            WBData     <= '0;
        end else if (!Stall) begin
            WBRegister <= WriteRegister_M;
            WBRegWrite <= RegWrite_M;
            WBData     <= sel_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WBRegWrite && WBRegister != 5'd0) begin
            regs[WBRegister] <= WBData;
        end
    end

    always_comb begin
        ReadData1 = '0;
        if (ReadRegister1 != 5'd0) begin
            if (WBRegWrite && WBRegister == ReadRegister1) begin
                ReadData1 = WBData;
            end else begin
                ReadData1 = regs[ReadRegister1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (ReadRegister2 != 5'd0) begin
            if (WBRegWrite && WBRegister == ReadRegister2) begin
                ReadData2 = WBData;
            end else begin
                ReadData2 = regs[ReadRegister2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized bench for regfile_wb against an architectural-view model.
// The model tracks the value each register presents to a reader.
module tb_regfile_wb;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [4:0]  WriteRegister_M;
    logic        RegWrite_M;
    logic        MemToReg_M;
    logic [31:0] ALUResult_M;
    logic [31:0] MemReadData_M;
    logic        Stall;
    logic        Flush;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  WBRegister;
    logic        WBRegWrite;
    logic [31:0] WBData;

    regfile_wb dut (
        .Clk(Clk),
        .Rst(Rst),
        .WriteRegister_M(WriteRegister_M),
        .RegWrite_M(RegWrite_M),
        .MemToReg_M(MemToReg_M),
        .ALUResult_M(ALUResult_M),
        .MemReadData_M(MemReadData_M),
        .Stall(Stall),
        .Flush(Flush),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .WBRegister(WBRegister),
        .WBRegWrite(WBRegWrite),
        .WBData(WBData)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    // Value a reader should see for each register (bypass makes a
    // captured write visible immediately, so commit timing is invisible).
    logic [31:0] vis [32];
    logic [4:0]  exp_reg;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        wb_dc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : vis[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) vis[i] = 32'h0;
        exp_reg  = 5'd0;
        exp_we   = 1'b0;
        exp_data = 32'h0;
        wb_dc    = 1'b0;
    endtask

    task automatic drive(input logic [4:0] wr, input logic we,
                         input logic m2r, input logic [31:0] alu,
                         input logic [31:0] mem, input logic st,
                         input logic fl);
        WriteRegister_M = wr;
        RegWrite_M      = we;
        MemToReg_M      = m2r;
        ALUResult_M     = alu;
        MemReadData_M   = mem;
        Stall           = st;
        Flush           = fl;
    endtask

    // One rising edge: update the model from pre-edge inputs, then check WB.
    task automatic tick();
        logic [31:0] s;
        @(posedge Clk);
        s = MemToReg_M ? MemReadData_M : ALUResult_M;
        if (Flush) begin
            exp_we = 1'b0;
            wb_dc  = 1'b1;
        end else if (!Stall) begin
            exp_reg  = WriteRegister_M;
            exp_we   = RegWrite_M;
            exp_data = s;
            wb_dc    = 1'b0;
            if (RegWrite_M && WriteRegister_M != 5'd0)
                vis[WriteRegister_M] = s;
        end
        #1;
        chk("wb_we", {31'h0, WBRegWrite}, {31'h0, exp_we});
        if (!wb_dc) begin
            chk("wb_reg", {27'h0, WBRegister}, {27'h0, exp_reg});
            chk("wb_data", WBData, exp_data);
        end
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
        chk("rd1", ReadData1, expect_rd(a1));
        chk("rd2", ReadData2, expect_rd(a2));
    endtask

    task automatic sweep_zero();
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = a[4:0];
            ReadRegister2 = 5'(31 - a);
            #1;
            chk("rst_rd1", ReadData1, 32'h0);
            chk("rst_rd2", ReadData2, 32'h0);
        end
    endtask

    initial begin
        Rst = 1'b0;
        drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        model_reset();
        #2;
        chk("rst_we", {31'h0, WBRegWrite}, 32'h0);
        chk("rst_reg", {27'h0, WBRegister}, 32'h0);
        chk("rst_data", WBData, 32'h0);
        sweep_zero();
        @(negedge Clk);
        Rst = 1'b1;

        // basic write-back through ALU result
        drive(5'd9, 1'b1, 1'b0, 32'h0000_1234, 32'hCAFE_0000, 1'b0, 1'b0);
        tick();
        drive(5'd9, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ReadRegister1 = 5'd9;
        #1;
        chk("bw_bypass", ReadData1, 32'h0000_1234);
        tick();
        rd(5'd9, 5'd1);
        chk("bw_array", ReadData1, 32'h0000_1234);
        tick();
        rd(5'd9, 5'd9);

        // MemToReg selects load data
        drive(5'd17, 1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        chk("m2r_wbdata", WBData, 32'hDEAD_BEEF);
        drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rd(5'd9, 5'd17);
        chk("m2r_rd2", ReadData2, 32'hDEAD_BEEF);
        tick();
        rd(5'd17, 5'd17);

        // register 0 never written, not even through bypass
        drive(5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        tick();
        chk("r0_wbreg", {27'h0, WBRegister}, 32'h0);
        chk("r0_wbwe", {31'h0, WBRegWrite}, 32'h1);
        ReadRegister1 = 5'd0;
        #1;
        chk("r0_bypass", ReadData1, 32'h0);
        tick();
        ReadRegister1 = 5'd0;
        #1;
        chk("r0_array", ReadData1, 32'h0);

        // stall holds, flush+stall inserts a bubble
        drive(5'd3, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
        tick();
        drive(5'd4, 1'b1, 1'b0, 32'h5A5A_5A5A, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_reg", {27'h0, WBRegister}, 32'd3);
            chk("st_data", WBData, 32'hA5A5_A5A5);
            rd(5'd4, 5'd3);
            chk("st_r4", ReadData1, 32'h0);
        end
        Flush = 1'b1;
        tick();
        chk("fl_we", {31'h0, WBRegWrite}, 32'h0);
        rd(5'd4, 5'd3);
        chk("fl_r4", ReadData1, 32'h0);
        chk("fl_r3", ReadData2, 32'hA5A5_A5A5);

        // both ports on the WB register before its commit edge
        drive(5'd7, 1'b1, 1'b0, 32'h7777_0007, 32'h0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd7;
        #1;
        chk("dp_rd1", ReadData1, 32'h7777_0007);
        chk("dp_rd2", ReadData2, 32'h7777_0007);

        // randomized traffic, with one asynchronous reset mid-run
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1;
            logic [4:0] a2;
            drive(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), $urandom, $urandom,
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 9) == 0));
            tick();
            a1 = ($urandom_range(0, 2) == 0) ? WBRegister
                                            : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? a1
                                            : 5'($urandom_range(0, 31));
            rd(a1, a2);
            rd(5'($urandom_range(0, 31)), exp_reg);
            if (n == 200) begin
                drive(5'd12, 1'b1, 1'b0, 32'h1212_1212, 32'h0, 1'b0, 1'b0);
                tick();
                #1;
                Rst = 1'b0;
                model_reset();
                #1;
                chk("arst_we", {31'h0, WBRegWrite}, 32'h0);
                sweep_zero();
                @(negedge Clk);
                Rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Write-back stage and 32x32 register file for the pipelined MIPS datapath. It consumes the 5-bit destination register chosen by the RegDst 2:1 mux, together with the MEM-stage result and controls, and latches them into a MEM/WB pipeline register. On the next edge it commits the value into the register array. It serves the two ID-stage read ports with internal write-to-read bypass and exports the WB-stage state to the forwarding unit.

## Interface
- DATA_WIDTH, 32, width of every data word and register.
- NUM_REGS, 32, register count; address width fixed at 5.

- Clk  in  1  system clock, rising-edge active.
- Rst  in  1  asynchronous, active-low reset.
- WriteRegister_M  in  5  destination register from the RegDst mux (MEM stage).
- RegWrite_M  in  1  MEM-stage write enable.
- MemToReg_M  in  1  1 selects MemReadData_M, 0 selects ALUResult_M.
- ALUResult_M  in  32  ALU result carried through MEM.
- MemReadData_M  in  32  data-memory load data.
- Stall  in  1  hold the MEM/WB register.
- Flush  in  1  insert a bubble into MEM/WB.
- ReadRegister1, ReadRegister2  in  5 each  ID-stage read addresses.
- ReadData1, ReadData2  out  32 each  read data, combinational.
- WBRegister  out  5  MEM/WB destination register.
- WBRegWrite  out  1  MEM/WB write enable.
- WBData  out  32  MEM/WB write-back data.

## Operation
- One clock. Reset is asynchronous and active-low.
- Reset (Rst=0), applied asynchronously:
  - all NUM_REGS registers = 0
  - WBRegister = 0, WBRegWrite = 0, WBData = 0
  - any pending write is discarded, including when reset is asserted mid-operation.
- MEM/WB capture on each rising edge, with Rst=1:
  - Flush=1: WBRegWrite <= 0. WBRegister and WBData are don't-care; the bench drives them to 0. Flush has priority over Stall.
  - Flush=0, Stall=1: all MEM/WB fields hold.
  - Otherwise:
    - WBRegister <= WriteRegister_M
    - WBRegWrite <= RegWrite_M
    - WBData <= MemToReg_M ? MemReadData_M : ALUResult_M
    - The mux selection happens before the register, so WBData is already the selected value.
- Array commit on each rising edge: if WBRegWrite=1 and WBRegister!=0, regs[WBRegister] <= WBData.
  - This uses the pre-edge MEM/WB contents.
  - While stalled, the same write repeats every cycle. This is idempotent and allowed.
- Register 0:
  - never written
  - reads always return 0, including through the bypass path.
- Read port x (1 or 2), combinational:
  - if ReadRegisterx==0: 0
  - else if WBRegWrite=1 and WBRegister==ReadRegisterx: WBData (bypass)
  - else regs[ReadRegisterx].
- Both read ports may address the same register, or the WB register, at the same time. Each port resolves independently.
- Register width is exactly DATA_WIDTH. There is no sign or zero extension inside the block.

## Timing
- MEM-stage inputs sampled at edge k appear on WB outputs after edge k.
- Those values enter the array at edge k+1.
- Read data reflects the new value from edge k onward via the bypass. This is equivalent to the classic write-first-half / read-second-half behaviour.
- Read latency is 0 cycles (purely combinational from ReadRegisterx, the WB state, and the array).
- Stall asserted at edge k: WB outputs after edge k equal those after edge k-1.
- Flush and Stall both high: a bubble is inserted (WBRegWrite=0).
- Rst deassertion is synchronised externally. The first capture occurs on the first rising edge with Rst=1.

## Test plan
- Reset: write several registers, then pulse Rst=0 between edges.
  - ReadData1/2 = 0 for all 32 addresses.
  - WBRegWrite = 0 immediately, without waiting for a clock.
- Basic write-back:
  - Drive WriteRegister_M=5'd9, RegWrite_M=1, MemToReg_M=0, ALUResult_M=32'h0000_1234 for one edge, then RegWrite_M=0.
  - ReadRegister1=9 returns 32'h0000_1234 in the cycle after capture (bypass) and in all later cycles (array).
- MemToReg select:
  - Drive WriteRegister_M=5'd17, MemToReg_M=1, MemReadData_M=32'hDEAD_BEEF, ALUResult_M=32'h1.
  - ReadRegister2=17 returns 32'hDEAD_BEEF.
  - WBData = 32'hDEAD_BEEF.
- Register 0:
  - Drive WriteRegister_M=0, RegWrite_M=1, ALUResult_M=32'hFFFF_FFFF.
  - WBRegister=0 and WBRegWrite=1, yet ReadData1 for address 0 returns 0 in every cycle.
- Stall and Flush:
  - Capture reg 3 = 32'hA5A5_A5A5, then Stall=1 for 3 edges while the MEM inputs change to reg 4 = 32'h5A5A_5A5A.
  - WB outputs stay at reg 3 throughout, and reg 4 reads 0.
  - Then Flush=1 and Stall=1 together with RegWrite_M=1: after the edge WBRegWrite=0 and reg 4 still reads 0.
- Dual-port same address: ReadRegister1 = ReadRegister2 = WBRegister = 7 with WBRegWrite=1 and WBData=32'h7777_0007.
  - Both ports return 32'h7777_0007 before the commit edge.
